// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int unsigned          RETRY_W   = 4;
    localparam logic [RETRY_W-1:0]   RETRY_MAX = 4'd15;

    // Saturating increment for the restart counter; never wraps
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        return (v == RETRY_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// Generic 2-FF synchroniser, asynchronous active-high reset to 0.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    // Two-stage capture of an asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// iCE40 PLL reset sequencer, clocked by the 48 MHz reference clock.
// Drives PLL RESETB, qualifies LOCK and holds sys_rst until lock is stable.
// Optional build macro PLLSEQ_GLITCH_FILTER_EN: require GLITCH_CYCLES
// consecutive lock-low samples in RUN before declaring loss of lock.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned GLITCH_CYCLES = 4,
    parameter int unsigned CNT_W         = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_resetb,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    // Reject configurations the counter or the sequence cannot support
    if (RST_CYCLES < 2 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || GLITCH_CYCLES < 1
        || $clog2(RST_CYCLES) > CNT_W || $clog2(LOCK_TIMEOUT) > CNT_W
        || $clog2(STABLE_CYCLES) > CNT_W) begin : g_bad_params
        $error("pll_reset_seq: illegal parameter combination");
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lk;
    logic             loss;

    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

`ifdef PLLSEQ_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);

    // In RUN the shared counter holds the run length of consecutive lock-low samples
    always_comb begin
        loss = !lk && (cnt_q == GLITCH_LAST);
    end
`else
    // Any lock-low sample in RUN is a loss of lock
    always_comb begin
        loss = !lk;
    end
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PLL_RST;
            cnt_q      <= '0;
            pll_resetb <= 1'b0;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            unique case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q    <= WAIT_LOCK;
                        cnt_q      <= '0;
                        pll_resetb <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock wins over a coincident timeout
                    if (lk) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q    <= PLL_RST;
                        cnt_q      <= '0;
                        pll_resetb <= 1'b0;
                        retry_cnt  <= retry_inc(retry_cnt);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (loss) begin
                        state_q    <= PLL_RST;
                        cnt_q      <= '0;
                        pll_resetb <= 1'b0;
                        sys_rst    <= 1'b1;
                        ready      <= 1'b0;
                        lock_lost  <= 1'b1;
                        retry_cnt  <= retry_inc(retry_cnt);
                    end else begin
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
`ifdef PLLSEQ_GLITCH_FILTER_EN
                        cnt_q   <= lk ? '0 : cnt_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= PLL_RST;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
